deswizzle_rx: RTL and testbench

//  Receive end of the swizzle datapath: accepts a swizzled WIDTH-bit word serially, one bit per

---
 rtl/deswizzle_pkg.sv | 18 +
 rtl/deswizzle_shift_reg.sv | 45 ++++
 rtl/deswizzle_rx.sv | 104 ++++++++++
 tb/tb_deswizzle_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deswizzle_pkg.sv
// Shared types and constants for the deswizzle receive path.
// Optional parity beat is enabled by defining DESWIZZLE_RX_PARITY_EN.
package deswizzle_pkg;

    typedef enum logic [1:0] {
        RECV   = 2'd0,
        PARITY = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int DEFAULT_CNT_W = 16;

    // Index counter width; never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/deswizzle_shift_reg.sv
// Serial shift-in register with bit index and running parity of the data bits.
// Shifting left lands the first received bit in the MSB, undoing the link's bit reversal.
module deswizzle_shift_reg
    import deswizzle_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] data_next_o,
    output logic             last_o,
    output logic             par_o
);

    localparam int IDX_W = idx_width(WIDTH);

    logic [WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0] idx_q;
    logic             par_q;

    assign data_next_o = {shreg_q[WIDTH-2:0], bit_i};
    assign last_o      = (idx_q == IDX_W'(WIDTH - 1));
    assign par_o       = par_q;

    // Shift one data bit per enabled beat; clear when the held word leaves.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else if (clear_i) begin
            shreg_q <= '0;
            idx_q   <= '0;
            par_q   <= 1'b0;
        end else if (shift_i) begin
            shreg_q <= data_next_o;
            idx_q   <= last_o ? '0 : idx_q + 1'b1;
            par_q   <= par_q ^ bit_i;
        end
    end

endmodule

// File: rtl/deswizzle_rx.sv
// Receive end of the swizzle link: rebuilds a WIDTH-bit word from a serial bit stream,
// holds it until the consumer takes it, and counts delivered words.
// Define DESWIZZLE_RX_PARITY_EN to expect an even-parity beat after each word.
//
// state  | meaning
// RECV   | accepting data bits sw[0]..sw[WIDTH-1]
// PARITY | accepting the parity beat (parity build only)
// HOLD   | complete word presented, waiting for out_ready
module deswizzle_rx
    import deswizzle_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] word_count
);

    state_t           state_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_err_q;
    logic [CNT_W-1:0] count_q;

    logic             beat;
    logic             handshake;
    logic [WIDTH-1:0] data_next;
    logic             last_bit;
    logic             par;

    assign in_ready   = (state_q != HOLD);
    assign out_valid  = (state_q == HOLD);
    assign beat       = in_valid & in_ready;
    assign handshake  = out_valid & out_ready;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign word_count = count_q;

    deswizzle_shift_reg #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clock      (clock),
        .reset      (reset),
        .shift_i    (beat && (state_q == RECV)),
        .clear_i    (handshake),
        .bit_i      (in_bit),
        .data_next_o(data_next),
        .last_o     (last_bit),
        .par_o      (par)
    );

`ifndef DESWIZZLE_RX_PARITY_EN
    logic unused_par;
    assign unused_par = par;
`endif

    // Sequencing FSM: capture the word on its final data beat, release it on handshake.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RECV;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            unique case (state_q)
                RECV: begin
                    if (beat && last_bit) begin
                        out_data_q <= data_next;
`ifdef DESWIZZLE_RX_PARITY_EN
                        state_q    <= PARITY;
`else
                        state_q    <= HOLD;
`endif
                    end
                end
                PARITY: begin
`ifdef DESWIZZLE_RX_PARITY_EN
                    if (beat) begin
                        out_err_q <= par ^ in_bit;
                        state_q   <= HOLD;
                    end
`else
                    state_q <= RECV;
`endif
                end
                HOLD: begin
                    if (out_ready) begin
                        count_q <= count_q + 1'b1;
                        state_q <= RECV;
                    end
                end
                default: state_q <= RECV;
            endcase
        end
    end

endmodule

// File: tb/tb_deswizzle_rx.sv
// Directed self-checking bench for deswizzle_rx (WIDTH=8, CNT_W=16).
// A second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_deswizzle_rx;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_err;
    logic [15:0] word_count;

    logic       in_ready_w;
    logic       out_valid_w;
    logic [7:0] out_data_w;
    logic       out_err_w;
    logic [1:0] word_count_w;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_count = 0;

    deswizzle_rx #(.WIDTH(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .word_count(word_count)
    );

    deswizzle_rx #(.WIDTH(8), .CNT_W(2)) dut_w (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready_w), .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_err(out_err_w), .word_count(word_count_w)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = v[7-k];
        return r;
    endfunction

    // Present one bit and hold it until accepted; returns at a falling edge.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_bit_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] sw, input int gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(sw[i]);
            if (i < 7) begin
                repeat (gap) begin
                    in_bit = ~in_bit;
                    @(negedge clock);
                end
            end
        end
    endtask

    task automatic send_word(input logic [7:0] sw, input int gap);
        send_bits(sw, gap);
`ifdef DESWIZZLE_RX_PARITY_EN
        send_bit(^sw);
`endif
    endtask

    // Word is held now; check it, let it leave with out_ready=1, check count.
    task automatic expect_word(input string name, input logic [7:0] exp_data);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s_data: out_valid=%0b out_data=%h required 1 %h", name, out_valid, out_data, exp_data);
        end
        out_ready = 1'b1;
        @(negedge clock);
        exp_count++;
        n_checks++;
        if (out_valid !== 1'b0 || word_count !== 16'(exp_count) || out_data !== exp_data) begin
            n_fail++;
            $display("FAIL %s_handshake: out_valid=%0b count=%0d data=%h required 0 %0d %h",
                     name, out_valid, word_count, out_data, exp_count, exp_data);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_err !== 1'b0 || word_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: rdy=%0b vld=%0b data=%h err=%0b cnt=%h required 1 0 00 0 0000",
                     in_ready, out_valid, out_data, out_err, word_count);
        end
        @(negedge clock);
        reset = 1'b0;
        exp_count = 0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send_word(8'hC5, 0);
        n_checks++;
        if (rev8(8'hC5) !== 8'hA3 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_err: out_err=%0b required 0", out_err);
        end
        expect_word("basic", 8'hA3);
    endtask

    task automatic test_patterns;
        out_ready = 1'b1;
        send_word(8'h80, 0);
        expect_word("pat_01", 8'h01);
        send_word(8'hFF, 0);
        expect_word("pat_ff", 8'hFF);
        send_word(8'hC5, 2);
        expect_word("pat_gaps", 8'hA3);
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_word(8'h35, 0);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hAC) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: rdy=%0b vld=%0b data=%h required 0 1 ac",
                         c, in_ready, out_valid, out_data);
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        expect_word("hold_release", 8'hAC);
        send_word(8'h80, 0);
        expect_word("after_hold", 8'h01);
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 ||
            out_err !== 1'b0 || word_count !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%0b vld=%0b data=%h err=%0b cnt=%h required 1 0 00 0 0000",
                     in_ready, out_valid, out_data, out_err, word_count);
        end
        exp_count = 0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        send_word(8'hC5, 0);
        expect_word("post_reset", 8'hA3);
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        send_word(8'h01, 0);
        expect_word("wrap_a", 8'h80);
        send_word(8'h02, 1);
        expect_word("wrap_b", 8'h40);
        send_word(8'h0F, 0);
        expect_word("wrap_c", 8'hF0);
        n_checks++;
        if (word_count !== 16'd4 || word_count_w !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_to_zero: cnt=%0d cnt_small=%0d required 4 0", word_count, word_count_w);
        end
        send_word(8'hC5, 0);
        expect_word("wrap_d", 8'hA3);
        n_checks++;
        if (word_count_w !== 2'd1 || out_data_w !== 8'hA3) begin
            n_fail++;
            $display("FAIL wrap_after: cnt_small=%0d data_small=%h required 1 a3", word_count_w, out_data_w);
        end
    endtask

`ifdef DESWIZZLE_RX_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b0;
        send_bits(8'hC5, 0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL par_wait: vld=%0b rdy=%0b required 0 1", out_valid, in_ready);
        end
        send_bit(1'b0);
        n_checks++;
        if (out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL par_good: out_err=%0b required 0", out_err);
        end
        expect_word("par_good", 8'hA3);
        out_ready = 1'b0;
        send_bits(8'hC5, 0);
        send_bit(1'b1);
        n_checks++;
        if (out_err !== 1'b1) begin
            n_fail++;
            $display("FAIL par_bad: out_err=%0b required 1", out_err);
        end
        expect_word("par_bad", 8'hA3);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_mid_reset();
        test_wrap();
`ifdef DESWIZZLE_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
